// File: rtl/cselector_pkg.sv
// Shared types and helpers for the N-way click selector and its delay counter.
package cselector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        DLY,
        DRV,
        WAIT
    } state_e;

    localparam int unsigned JOIN_ANY = 0;
    localparam int unsigned JOIN_ALL = 1;

    // Bits needed to hold values 0..delay, never less than one.
    function automatic int unsigned cnt_width(input int unsigned delay);
        return (delay + 1 <= 2) ? 1 : $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/cselector_delay_cnt.sv
// Loadable down-counter standing in for the fixed settle-delay element.
module cselector_delay_cnt
    import cselector_pkg::*;
#(
    parameter int unsigned DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int unsigned CW = cnt_width(DELAY);

    logic [CW-1:0] count;
    logic [CW-1:0] count_d;

    // Load DELAY-1 so done is seen on the DELAY-th cycle after the load edge.
    always_comb begin
        count_d = count;
        if (load) begin
            count_d = CW'(DELAY - 1);
        end else if (count != '0) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            done  <= 1'b1;
        end else begin
            count <= count_d;
            done  <= (count_d == '0);
        end
    end

endmodule

// File: rtl/cselectorn_cache_sync.sv
// Clocked N-way click selector: accepts an upstream drive, fans it out to the
// valid downstream channels after a settle delay, then joins their frees.
module cselectorn_cache_sync
    import cselector_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DELAY    = 2,
    parameter int unsigned JOIN_ALL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_drive,
    output logic         o_free,
    output logic         o_fire,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_driveNext,
    input  logic [N-1:0] i_freeNext,
    output logic         o_busy,
    output logic         o_skip,
    output logic         o_overrun
);

    state_e       state, state_d;
    logic         pending, pending_d;
    logic [N-1:0] mask, mask_d;
    logic [N-1:0] join_vec, join_d;
    logic         cnt_load, cnt_done;
    logic         overrun_d, fire_d, busy_d, skip_d;
    logic [N-1:0] drive_d;

    cselector_delay_cnt #(
        .DELAY (DELAY)
    ) u_delay_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .done (cnt_done)
    );

    always_comb begin
        state_d   = state;
        pending_d = pending;
        mask_d    = mask;
        join_d    = join_vec;
        cnt_load  = 1'b0;
        overrun_d = 1'b0;
        fire_d    = 1'b0;
        busy_d    = 1'b0;
        skip_d    = 1'b0;
        drive_d   = '0;

        // A drive arriving mid-transaction is buffered once, then dropped.
        if (state != IDLE && i_drive) begin
            if (!pending) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (i_drive || pending) begin
                    state_d   = FIRE;
                    pending_d = pending && i_drive;
                end
            end
            FIRE: begin
                cnt_load = 1'b1;
                state_d  = DLY;
            end
            DLY: begin
                if (cnt_done) begin
                    mask_d  = i_valid;
                    state_d = DRV;
                end
            end
            DRV: begin
                if (mask == '0) begin
                    state_d = IDLE;
                end else begin
                    join_d  = mask;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (JOIN_ALL == cselector_pkg::JOIN_ALL) begin
                    join_d = join_vec & ~i_freeNext;
                    if (join_d == '0) begin
                        state_d = IDLE;
                    end
                end else if ((i_freeNext & mask) != '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they leave a flop.
        fire_d  = (state_d == FIRE);
        busy_d  = (state_d != IDLE);
        drive_d = (state_d == DRV) ? mask_d : '0;
        skip_d  = (state_d == DRV) && (mask_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            mask        <= '0;
            join_vec    <= '0;
            o_fire      <= 1'b0;
            o_free      <= 1'b0;
            o_busy      <= 1'b0;
            o_driveNext <= '0;
            o_skip      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_d;
            pending     <= pending_d;
            mask        <= mask_d;
            join_vec    <= join_d;
            o_fire      <= fire_d;
            o_free      <= fire_d;
            o_busy      <= busy_d;
            o_driveNext <= drive_d;
            o_skip      <= skip_d;
            o_overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_cselectorn_cache_sync.sv
// Scoreboard bench for the N-way click selector in any-join and all-join modes.
module tb_cselectorn_cache_sync;

    localparam int unsigned N = 4;
    localparam int K_FIRE = 0;
    localparam int K_DRV  = 1;
    localparam int K_SKIP = 2;
    localparam int K_OVR  = 3;
    localparam int K_IDLE = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         drv_a, fire_a, free_a, busy_a, skip_a, ovr_a;
    logic [N-1:0] val_a, fr_a, dn_a;
    logic         drv_b, fire_b, free_b, busy_b, skip_b, ovr_b;
    logic [N-1:0] val_b, fr_b, dn_b;

    cselectorn_cache_sync #(.N(N), .DELAY(2), .JOIN_ALL(0)) dut_any (
        .clk(clk), .rst(rst), .i_drive(drv_a), .o_free(free_a), .o_fire(fire_a),
        .i_valid(val_a), .o_driveNext(dn_a), .i_freeNext(fr_a), .o_busy(busy_a),
        .o_skip(skip_a), .o_overrun(ovr_a)
    );

    cselectorn_cache_sync #(.N(N), .DELAY(2), .JOIN_ALL(1)) dut_all (
        .clk(clk), .rst(rst), .i_drive(drv_b), .o_free(free_b), .o_fire(fire_b),
        .i_valid(val_b), .o_driveNext(dn_b), .i_freeNext(fr_b), .o_busy(busy_b),
        .o_skip(skip_b), .o_overrun(ovr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int dut;
        int kind;
        int cyc;
        int val;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push_exp(input int d, input int k, input int c, input int v);
        exp_t e;
        e.dut = d; e.kind = k; e.cyc = c; e.val = v;
        sb.push_back(e);
    endtask

    function automatic string kname(input int k);
        case (k)
            K_FIRE:  return "fire";
            K_DRV:   return "drive_next";
            K_SKIP:  return "skip";
            K_OVR:   return "overrun";
            default: return "busy_fall";
        endcase
    endfunction

    // Match an observed output event against the oldest pending expectation of its kind.
    task automatic observe(input int d, input int k, input int v);
        int idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].dut == d && sb[i].kind == k) idx = i;
        if (idx < 0) begin
            n_total++;
            $display("FAIL unexpected_%s_dut%0d: got event value %0d at cycle %0d, expected none",
                     kname(k), d, v, cyc);
        end else begin
            check($sformatf("%s_cycle_dut%0d", kname(k), d), cyc, sb[idx].cyc);
            if (k == K_DRV) check($sformatf("%s_value_dut%0d", kname(k), d), v, sb[idx].val);
            sb.delete(idx);
        end
    endtask

    task automatic scan(input int d, input logic fire, input logic free, input logic busy,
                        input logic prev_busy, input logic [N-1:0] dn, input logic skip,
                        input logic ovr);
        if (fire || free) begin
            check($sformatf("free_eq_fire_dut%0d", d), int'(free), int'(fire));
            observe(d, K_FIRE, 0);
        end
        if (dn != '0) observe(d, K_DRV, int'(dn));
        if (skip) observe(d, K_SKIP, 0);
        if (ovr) observe(d, K_OVR, 0);
        if (prev_busy && !busy) observe(d, K_IDLE, 0);
    endtask

    logic pb_a = 1'b0;
    logic pb_b = 1'b0;
    always @(negedge clk) begin
        scan(0, fire_a, free_a, busy_a, pb_a, dn_a, skip_a, ovr_a);
        scan(1, fire_b, free_b, busy_b, pb_b, dn_b, skip_b, ovr_b);
        pb_a = busy_a;
        pb_b = busy_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_a();
        drv_a = 1'b1; tick(); drv_a = 1'b0;
    endtask

    task automatic pulse_b();
        drv_b = 1'b1; tick(); drv_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        drv_a = 1'b0; val_a = '0; fr_a = '0;
        drv_b = 1'b0; val_b = '0; fr_b = '0;
        #1 rst = 1'b0;
        #2;
        check("rst_fire_a", int'(fire_a), 0);
        check("rst_free_a", int'(free_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_drive_next_a", int'(dn_a), 0);
        check("rst_skip_a", int'(skip_a), 0);
        check("rst_overrun_a", int'(ovr_a), 0);
        check("rst_busy_b", int'(busy_b), 0);
        check("rst_drive_next_b", int'(dn_b), 0);
        repeat (3) tick();
        rst = 1'b1;

        // Basic fan-out, undriven-channel frees ignored
        val_a = 4'b0101;
        run_to(10); t = cyc;
        push_exp(0, K_FIRE, t + 1, 0);
        push_exp(0, K_DRV, t + 4, 4'b0101);
        push_exp(0, K_IDLE, t + 7, 0);
        pulse_a();
        run_to(t + 5);
        fr_a = 4'b1010; tick();
        fr_a = 4'b0100; tick();
        fr_a = '0;

        // Empty valid mask skips instead of waiting
        run_to(t + 10); t = cyc;
        val_a = '0;
        push_exp(0, K_FIRE, t + 1, 0);
        push_exp(0, K_SKIP, t + 4, 0);
        push_exp(0, K_IDLE, t + 5, 0);
        pulse_a();

        // Valid sampled on the last delay cycle only
        run_to(t + 10); t = cyc;
        val_a = 4'b0001;
        push_exp(0, K_FIRE, t + 1, 0);
        push_exp(0, K_DRV, t + 4, 4'b0010);
        push_exp(0, K_IDLE, t + 7, 0);
        pulse_a();
        run_to(t + 3); val_a = 4'b0010;
        tick();        val_a = 4'b1000;
        run_to(t + 6); fr_a = 4'b0010;
        tick();        fr_a = '0;

        // Pending buffer, overrun, and coincident drive with pending in IDLE
        run_to(t + 12); t = cyc;
        val_a = 4'b0011;
        push_exp(0, K_FIRE, t + 1, 0);
        push_exp(0, K_DRV, t + 4, 4'b0011);
        push_exp(0, K_OVR, t + 6, 0);
        push_exp(0, K_IDLE, t + 8, 0);
        push_exp(0, K_FIRE, t + 9, 0);
        push_exp(0, K_DRV, t + 12, 4'b0011);
        push_exp(0, K_IDLE, t + 15, 0);
        push_exp(0, K_FIRE, t + 16, 0);
        push_exp(0, K_DRV, t + 19, 4'b0011);
        push_exp(0, K_IDLE, t + 21, 0);
        pulse_a();
        run_to(t + 3);  pulse_a();
        run_to(t + 5);  pulse_a();
        run_to(t + 7);  fr_a = 4'b0001; tick(); fr_a = '0;
        pulse_a();
        run_to(t + 14); fr_a = 4'b0010; tick(); fr_a = '0;
        run_to(t + 20); fr_a = 4'b0001; tick(); fr_a = '0;

        // Asynchronous reset in WAIT with a pending drive buffered
        run_to(t + 25); t = cyc;
        val_a = 4'b0100;
        push_exp(0, K_FIRE, t + 1, 0);
        push_exp(0, K_DRV, t + 4, 4'b0100);
        push_exp(0, K_IDLE, t + 6, 0);
        pulse_a();
        run_to(t + 2); pulse_a();
        run_to(t + 6);
        #1 rst = 1'b0;
        #1;
        check("midrst_busy_a", int'(busy_a), 0);
        check("midrst_fire_a", int'(fire_a), 0);
        check("midrst_drive_next_a", int'(dn_a), 0);
        check("midrst_overrun_a", int'(ovr_a), 0);
        tick();
        rst = 1'b1;
        run_to(t + 8);  fr_a = 4'b0100; tick(); fr_a = '0;
        run_to(t + 10);
        push_exp(0, K_FIRE, t + 11, 0);
        push_exp(0, K_DRV, t + 14, 4'b0100);
        push_exp(0, K_IDLE, t + 17, 0);
        pulse_a();
        run_to(t + 16); fr_a = 4'b0100; tick(); fr_a = '0;

        // Join-all: every driven channel must free, multi-bit frees credited
        run_to(t + 22); t = cyc;
        val_b = 4'b1011;
        push_exp(1, K_FIRE, t + 1, 0);
        push_exp(1, K_DRV, t + 4, 4'b1011);
        push_exp(1, K_IDLE, t + 9, 0);
        pulse_b();
        run_to(t + 5);
        fr_b = 4'b0001; tick();
        fr_b = 4'b0100; tick();
        fr_b = '0;
        run_to(t + 8);  fr_b = 4'b1010; tick(); fr_b = '0;

        run_to(t + 15);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
